// File: rtl/acqcap_pkg.sv
// -----------------------------------------------------------------------------
// acqcap_pkg
//
// Shared types for the acquisition-buffer capture writer: the controller state
// encoding, the capture mode encoding, and small helpers used by both the
// controller and the top level.
// -----------------------------------------------------------------------------
package acqcap_pkg;

    // Controller state. IDLE after reset, ARMED waits for a trigger,
    // CAPTURE writes samples, DONE holds until the next arm.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } acqcap_state_t;

    // Capture mode as held by the controller after an arm.
    typedef enum logic [1:0] {
        MODE_FREERUN    = 2'd0,
        MODE_TRIGGERED  = 2'd1,
        MODE_CONTINUOUS = 2'd2
    } acqcap_mode_t;

    // Map the raw 2-bit mode input onto the capture mode. Code 3 is an
    // alias of free-run, so it never reaches the controller as its own value.
    function automatic acqcap_mode_t decode_mode(input logic [1:0] code);
        case (code)
            2'd1:    return MODE_TRIGGERED;
            2'd2:    return MODE_CONTINUOUS;
            default: return MODE_FREERUN;
        endcase
    endfunction

    // States in which a capture is in progress (waiting or writing).
    function automatic logic state_is_busy(input acqcap_state_t s);
        return (s == ST_ARMED) || (s == ST_CAPTURE);
    endfunction

endpackage : acqcap_pkg

// File: rtl/acqcap_ctrl.sv
// -----------------------------------------------------------------------------
// acqcap_ctrl
//
// Capture controller: FSM, configuration latched at arm, decimation counter,
// write address and sample counter. Produces one write strobe plus address
// per accepted sample; the data path lives in the top level.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   arm      in   start/restart capture (pulse), latches mode/decim/length
//   stop     in   abort capture (pulse)
//   trig     in   start event while ARMED
//   mode     in   raw mode code (0 free-run, 1 triggered, 2 continuous, 3 = 0)
//   decim    in   accept one sample every decim+1 capture cycles
//   length   in   samples per capture, 0 means 2^ADDRWIDTH
//   wr_en    out  accepted sample is to be written this cycle
//   wr_addr  out  write address for the accepted sample
//   busy     out  registered: state is ARMED or CAPTURE
//   done     out  registered: state is DONE
//   wrapped  out  registered: continuous capture has wrapped since arm
// -----------------------------------------------------------------------------
module acqcap_ctrl
    import acqcap_pkg::*;
#(
    parameter int ADDRWIDTH = 12,
    parameter int DECWIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 stop,
    input  logic                 trig,
    input  logic [1:0]           mode,
    input  logic [DECWIDTH-1:0]  decim,
    input  logic [ADDRWIDTH:0]   length,
    output logic                 wr_en,
    output logic [ADDRWIDTH-1:0] wr_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 wrapped
);

    acqcap_state_t        state_q;
    acqcap_state_t        state_d;
    acqcap_mode_t         mode_arm;
    acqcap_mode_t         mode_q;
    logic [DECWIDTH-1:0]  decim_q;
    logic [DECWIDTH-1:0]  dec_cnt_q;
    logic [ADDRWIDTH:0]   len_q;
    logic [ADDRWIDTH:0]   len_eff;
    logic [ADDRWIDTH:0]   count_q;
    logic [ADDRWIDTH:0]   count_inc;
    logic [ADDRWIDTH-1:0] addr_q;
    logic                 accept;
    logic                 last_accept;
    logic                 wrapped_q;
    logic                 busy_q;
    logic                 done_q;

    assign mode_arm = decode_mode(mode);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample the pre-edge values of each other, independent of process order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. arm overrides everything, including a same-cycle stop
    // or trig; the live mode input decides where the arm lands.
    // -------------------------------------------------------------------------
    // NOTE: state_d gets its hold value first so that no path through the
    // case leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = (mode_arm == MODE_TRIGGERED) ? ST_ARMED : ST_CAPTURE;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (stop) begin
                        state_d = ST_DONE;
                    end else if (trig) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (stop || last_accept) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic. A sample is accepted whenever the decimation counter is
    // at zero in CAPTURE. It is written only if the capture is not being
    // aborted (stop) or restarted (arm) in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        accept      = (state_q == ST_CAPTURE) && (dec_cnt_q == '0);
        wr_en       = accept && !stop && !arm;
        count_inc   = count_q + 1'b1;
        // A programmed length of 0 stands for a full buffer.
        len_eff     = (len_q == '0) ? {1'b1, {ADDRWIDTH{1'b0}}} : len_q;
        last_accept = wr_en && (mode_q != MODE_CONTINUOUS) && (count_inc == len_eff);
    end

    // -------------------------------------------------------------------------
    // Latched configuration, decimation counter, address and sample count.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_FREERUN;
            decim_q   <= '0;
            len_q     <= '0;
            dec_cnt_q <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (arm) begin
            mode_q    <= mode_arm;
            decim_q   <= decim;
            len_q     <= length;
            dec_cnt_q <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (state_q == ST_CAPTURE) begin
            dec_cnt_q <= (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + 1'b1;
            if (wr_en) begin
                // Address rolls over naturally at 2^ADDRWIDTH.
                addr_q  <= addr_q + 1'b1;
                count_q <= count_inc;
                if ((mode_q == MODE_CONTINUOUS) && (&addr_q)) begin
                    wrapped_q <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status flags, registered from the next state so they line up exactly
    // with the state register without decoding glitches on the outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= state_is_busy(state_d);
            done_q <= (state_d == ST_DONE);
        end
    end

    assign wr_addr = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign wrapped = wrapped_q;

endmodule : acqcap_ctrl

// File: rtl/acqbuf_capture.sv
// -----------------------------------------------------------------------------
// acqbuf_capture
//
// N-channel capture writer for the acquisition / DAC-monitor BRAMs. One
// controller decides which samples are written and where; a two-stage
// pipeline carries the channel samples, the shared address and the write
// strobe to the BRAM write ports. A sample accepted in cycle t is presented
// on data_out/addr_out with we_out=1 in cycle t+2.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high reset (flushes the pipeline)
//   arm       in   start/restart capture (pulse)
//   stop      in   abort capture (pulse)
//   trig      in   start event for triggered mode
//   mode      in   0 free-run, 1 triggered, 2 continuous, 3 same as 0
//   decim     in   write one sample every decim+1 cycles
//   length    in   samples per capture, 0 means 2^ADDRWIDTH
//   din       in   per-channel samples
//   data_out  out  per-channel BRAM write data
//   addr_out  out  per-channel BRAM write address (identical across channels)
//   we_out    out  per-channel BRAM write enable (identical across channels)
//   busy      out  capture armed or running
//   done      out  capture finished
//   wrapped   out  continuous capture has wrapped at least once since arm
// -----------------------------------------------------------------------------
module acqbuf_capture
    import acqcap_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int DATAWIDTH = 256,
    parameter int ADDRWIDTH = 12,
    parameter int DECWIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 stop,
    input  logic                 trig,
    input  logic [1:0]           mode,
    input  logic [DECWIDTH-1:0]  decim,
    input  logic [ADDRWIDTH:0]   length,
    input  logic [DATAWIDTH-1:0] din      [0:NCH-1],
    output logic [DATAWIDTH-1:0] data_out [0:NCH-1],
    output logic [ADDRWIDTH-1:0] addr_out [0:NCH-1],
    output logic                 we_out   [0:NCH-1],
    output logic                 busy,
    output logic                 done,
    output logic                 wrapped
);

    logic                 ctrl_wr_en;
    logic [ADDRWIDTH-1:0] ctrl_wr_addr;

    logic                 s1_we;
    logic [ADDRWIDTH-1:0] s1_addr;
    logic [DATAWIDTH-1:0] s1_data [0:NCH-1];

    logic                 s2_we;
    logic [ADDRWIDTH-1:0] s2_addr;
    logic [DATAWIDTH-1:0] s2_data [0:NCH-1];

    acqcap_ctrl #(
        .ADDRWIDTH (ADDRWIDTH),
        .DECWIDTH  (DECWIDTH)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .arm     (arm),
        .stop    (stop),
        .trig    (trig),
        .mode    (mode),
        .decim   (decim),
        .length  (length),
        .wr_en   (ctrl_wr_en),
        .wr_addr (ctrl_wr_addr),
        .busy    (busy),
        .done    (done),
        .wrapped (wrapped)
    );

    // -------------------------------------------------------------------------
    // Write strobe and address pipeline. The strobe advances every cycle so a
    // reset flushes both stages; the address only moves with a real write so
    // the BRAM port stays quiet between samples.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_we   <= 1'b0;
            s1_addr <= '0;
            s2_we   <= 1'b0;
            s2_addr <= '0;
        end else begin
            s1_we <= ctrl_wr_en;
            if (ctrl_wr_en) begin
                s1_addr <= ctrl_wr_addr;
            end
            s2_we <= s1_we;
            if (s1_we) begin
                s2_addr <= s1_addr;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sample pipeline, loaded only alongside a write so data_out keeps the
    // last written word between samples.
    // -------------------------------------------------------------------------
    // NOTE: these wide arrays are ordinary pipeline flops, not a RAM, so they
    // take the reset: data_out must read zero after reset, and a stage-1 word
    // left over from before the reset must never surface later.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                s1_data[i] <= '0;
                s2_data[i] <= '0;
            end else begin
                if (ctrl_wr_en) begin
                    s1_data[i] <= din[i];
                end
                if (s1_we) begin
                    s2_data[i] <= s1_data[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel fan-out of the shared address and write enable.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NCH; g++) begin : g_fanout
        assign data_out[g] = s2_data[g];
        assign addr_out[g] = s2_addr;
        assign we_out[g]   = s2_we;
    end

endmodule : acqbuf_capture

// File: tb/tb_acqbuf_capture.sv
// -----------------------------------------------------------------------------
// tb_acqbuf_capture
//
// Self-checking bench for acqbuf_capture with a small geometry (16-deep
// buffer) so wrap and full-length captures are reached quickly. A
// transaction-level model predicts every write (cycle, address, data) and
// the status flags; a compare process checks the DUT against it on every
// cycle. Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_acqbuf_capture;

    localparam int NCH   = 3;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DECW  = 4;
    localparam int DEPTH = 1 << AW;

    logic            clk    = 1'b0;
    logic            reset  = 1'b1;
    logic            arm    = 1'b0;
    logic            stop   = 1'b0;
    logic            trig   = 1'b0;
    logic [1:0]      mode   = 2'd0;
    logic [DECW-1:0] decim  = '0;
    logic [AW:0]     length = '0;
    logic [DW-1:0]   din      [0:NCH-1];
    logic [DW-1:0]   data_out [0:NCH-1];
    logic [AW-1:0]   addr_out [0:NCH-1];
    logic            we_out   [0:NCH-1];
    logic            busy;
    logic            done;
    logic            wrapped;

    acqbuf_capture #(
        .NCH       (NCH),
        .DATAWIDTH (DW),
        .ADDRWIDTH (AW),
        .DECWIDTH  (DECW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .arm      (arm),
        .stop     (stop),
        .trig     (trig),
        .mode     (mode),
        .decim    (decim),
        .length   (length),
        .din      (din),
        .data_out (data_out),
        .addr_out (addr_out),
        .we_out   (we_out),
        .busy     (busy),
        .done     (done),
        .wrapped  (wrapped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    bit use_ramp = 1'b1;

    // Observed writes (for the directed literal checks).
    int obs_cyc  [$];
    int obs_addr [$];
    int obs_d0   [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Deterministic sample value for channel ch in cycle c.
    function automatic logic [DW-1:0] ramp(input int c, input int ch);
        return DW'(c * 4 + ch);
    endfunction

    // -------------------------------------------------------------------------
    // Reference model: phase of the capture, writes scheduled two cycles out.
    // -------------------------------------------------------------------------
    typedef enum {M_IDLE, M_WAIT, M_RUN, M_END} mph_t;
    typedef struct {
        int                 due;
        logic [AW-1:0]      addr;
        logic [NCH*DW-1:0]  data;
    } wr_t;

    mph_t m_ph = M_IDLE;
    bit   m_wrapped = 1'b0;
    int   m_mode, m_decim, m_len, m_next, m_nwr, m_age;
    wr_t  exp_q [$];

    task automatic model_step();
        wr_t e;
        if (reset) begin
            m_ph      = M_IDLE;
            m_wrapped = 1'b0;
            exp_q.delete();
        end else if (arm) begin
            m_mode    = (mode == 2'd3) ? 0 : int'(mode);
            m_decim   = int'(decim);
            m_len     = (length == '0) ? DEPTH : int'(length);
            m_next    = 0;
            m_nwr     = 0;
            m_age     = 0;
            m_wrapped = 1'b0;
            m_ph      = (mode == 2'd1) ? M_WAIT : M_RUN;
        end else if (m_ph == M_WAIT) begin
            if (stop) begin
                m_ph = M_END;
            end else if (trig) begin
                m_ph  = M_RUN;
                m_age = 0;
            end
        end else if (m_ph == M_RUN) begin
            if (stop) begin
                m_ph = M_END;
            end else if ((m_age % (m_decim + 1)) == 0) begin
                e.due  = cyc + 2;
                e.addr = AW'(m_next);
                for (int ch = 0; ch < NCH; ch++) e.data[ch*DW +: DW] = din[ch];
                exp_q.push_back(e);
                if (m_mode == 2 && m_next == DEPTH - 1) m_wrapped = 1'b1;
                m_next = (m_next + 1) % DEPTH;
                m_nwr++;
                if (m_mode != 2 && m_nwr == m_len) m_ph = M_END;
            end
            m_age++;
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // -------------------------------------------------------------------------
    // Per-cycle comparison, sampled on the falling edge.
    // -------------------------------------------------------------------------
    task automatic compare_cycle();
        logic [NCH-1:0] we_vec;
        logic [NCH-1:0] exp_vec;
        bit             exp_we;
        wr_t            e;
        for (int ch = 0; ch < NCH; ch++) we_vec[ch] = we_out[ch];
        exp_we  = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        exp_vec = exp_we ? '1 : '0;
        check("we_out", 64'(we_vec), 64'(exp_vec));
        if (exp_we) begin
            e = exp_q.pop_front();
            for (int ch = 0; ch < NCH; ch++) begin
                check("addr_out", 64'(addr_out[ch]), 64'(e.addr));
                check("data_out", 64'(data_out[ch]), 64'(e.data[ch*DW +: DW]));
            end
        end
        if (we_out[0]) begin
            obs_cyc.push_back(cyc);
            obs_addr.push_back(int'(addr_out[0]));
            obs_d0.push_back(int'(data_out[0]));
        end
        check("busy", 64'(busy), 64'(m_ph == M_WAIT || m_ph == M_RUN));
        check("done", 64'(done), 64'(m_ph == M_END));
        check("wrapped", 64'(wrapped), 64'(m_wrapped));
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) compare_cycle();
    end

    // Sample driver: ramp for directed scenarios, random otherwise.
    initial begin
        for (int ch = 0; ch < NCH; ch++) din[ch] = '0;
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++)
                din[ch] = use_ramp ? ramp(cyc, ch) : DW'($urandom);
        end
    end

    // -------------------------------------------------------------------------
    // Driver helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_cyc.delete();
        obs_addr.delete();
        obs_d0.delete();
    endtask

    // Pulse arm for one cycle (optionally with stop/trig); a = arm cycle.
    task automatic do_arm(input logic [1:0] m, input int dc, input int len,
                          input bit with_stop, input bit with_trig, output int a);
        tick();
        mode   = m;
        decim  = DECW'(dc);
        length = (AW+1)'(len);
        arm    = 1'b1;
        stop   = with_stop;
        trig   = with_trig;
        a      = cyc;
        tick();
        arm    = 1'b0;
        stop   = 1'b0;
        trig   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    initial begin
        int a, g, r;

        repeat (3) tick();
        chk_en = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            check("rst_we", 64'(we_out[ch]), 0);
            check("rst_addr", 64'(addr_out[ch]), 0);
            check("rst_data", 64'(data_out[ch]), 0);
        end
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_wrapped", 64'(wrapped), 0);
        reset = 1'b0;

        // Free-run, decim 0, length 8: first sample is din of the cycle after arm.
        settle(); clear_obs();
        do_arm(2'd0, 0, 8, 1'b0, 1'b0, a);
        tick_to(a + 14); settle();
        check("fr_count", obs_addr.size(), 8);
        for (int i = 0; i < obs_addr.size(); i++) begin
            check("fr_addr", obs_addr[i], i);
            check("fr_data", obs_d0[i], ramp(a + 1 + i, 0));
            check("fr_cycle", obs_cyc[i], a + 3 + i);
        end
        check("fr_done", 64'(done), 1);
        check("fr_busy", 64'(busy), 0);

        // Triggered, decim 2, length 4, trigger 10 cycles after arm.
        settle(); clear_obs();
        do_arm(2'd1, 2, 4, 1'b0, 1'b0, a);
        tick_to(a + 5);
        check("tr_armed_busy", 64'(busy), 1);
        tick_to(a + 10);
        trig = 1'b1; g = cyc;
        tick();
        trig = 1'b0;
        tick_to(g + 16); settle();
        check("tr_count", obs_addr.size(), 4);
        for (int i = 0; i < obs_addr.size(); i++) begin
            check("tr_addr", obs_addr[i], i);
            check("tr_data", obs_d0[i], ramp(g + 1 + 3 * i, 0));
            check("tr_cycle", obs_cyc[i], g + 3 + 3 * i);
        end
        check("tr_done", 64'(done), 1);

        // Continuous, decim 0: wrap after address 15, stop on the accept of address 5.
        settle(); clear_obs();
        do_arm(2'd2, 0, 3, 1'b0, 1'b0, a);
        tick_to(a + 16);
        check("ct_wrap_pre", 64'(wrapped), 0);
        tick_to(a + 17);
        check("ct_wrap_post", 64'(wrapped), 1);
        tick_to(a + 22);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick_to(a + 30); settle();
        check("ct_count", obs_addr.size(), 21);
        for (int i = 0; i < obs_addr.size(); i++) check("ct_addr", obs_addr[i], i % 16);
        if (obs_addr.size() > 0) check("ct_last_addr", obs_addr[obs_addr.size() - 1], 4);
        check("ct_done", 64'(done), 1);
        check("ct_wrapped", 64'(wrapped), 1);
        check("ct_busy", 64'(busy), 0);

        // Length 0 in mode 3 (alias of free-run): a full 16-word capture.
        settle(); clear_obs();
        do_arm(2'd3, 0, 0, 1'b0, 1'b0, a);
        tick_to(a + 22); settle();
        check("l0_count", obs_addr.size(), 16);
        for (int i = 0; i < obs_addr.size(); i++) check("l0_addr", obs_addr[i], i);
        check("l0_done", 64'(done), 1);
        check("l0_wrapped", 64'(wrapped), 0);

        // Re-arm from DONE together with stop: arm wins, address restarts at 0.
        settle(); clear_obs();
        do_arm(2'd0, 1, 2, 1'b1, 1'b0, a);
        check("as_busy", 64'(busy), 1);
        tick_to(a + 10); settle();
        check("as_count", obs_addr.size(), 2);
        if (obs_addr.size() == 2) begin
            check("as_addr0", obs_addr[0], 0);
            check("as_addr1", obs_addr[1], 1);
            check("as_spacing", obs_cyc[1] - obs_cyc[0], 2);
        end
        check("as_done", 64'(done), 1);

        // Arm together with trig in triggered mode: stays ARMED, nothing written.
        settle(); clear_obs();
        do_arm(2'd1, 0, 4, 1'b0, 1'b1, a);
        tick_to(a + 6);
        check("at_busy", 64'(busy), 1);
        check("at_done", 64'(done), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick_to(a + 10); settle();
        check("at_count", obs_addr.size(), 0);
        check("at_stopped", 64'(done), 1);

        // Reset with writes in flight: pipeline flushed from the next cycle.
        settle(); clear_obs();
        do_arm(2'd0, 0, 16, 1'b0, 1'b0, a);
        tick_to(a + 5);
        reset = 1'b1; r = cyc;
        settle();
        for (int ch = 0; ch < NCH; ch++) begin
            check("rm_we", 64'(we_out[ch]), 0);
            check("rm_addr", 64'(addr_out[ch]), 0);
            check("rm_data", 64'(data_out[ch]), 0);
        end
        check("rm_busy", 64'(busy), 0);
        check("rm_done", 64'(done), 0);
        check("rm_wrapped", 64'(wrapped), 0);
        tick();
        reset = 1'b0;
        tick_to(r + 8); settle();
        check("rm_count", obs_addr.size(), 3);

        // Randomized control traffic; configuration inputs churn every cycle.
        use_ramp = 1'b0;
        tick();
        for (int n = 0; n < 4000; n++) begin
            mode   = 2'($urandom);
            decim  = ($urandom_range(0, 9) == 0) ? DECW'($urandom) : DECW'($urandom_range(0, 3));
            length = (AW+1)'($urandom_range(0, 31));
            arm    = ($urandom_range(0, 39) == 0);
            stop   = ($urandom_range(0, 59) == 0);
            trig   = ($urandom_range(0, 14) == 0);
            reset  = ($urandom_range(0, 599) == 0);
            tick();
        end
        arm = 1'b0; stop = 1'b0; trig = 1'b0; reset = 1'b0;
        repeat (5) tick();
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_acqbuf_capture
